// File: rtl/pulse_bram_fp32_acc.sv
// Pulse-height accumulation store: single-port read-first word BRAM with a registered read port,
// plus a zero-latency IEEE-754 single-precision adder for the read-modify-write path.
module pulse_bram_fp32_acc #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [31:0]           addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic [31:0]           add_a,
  input  logic [31:0]           add_b,
  output logic [31:0]           add_result
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_douta;

  // Byte address to word index; upper bits give modulo-depth wrap.
  assign w_idx    = addra[ADDR_WIDTH+1:2];
  assign w_unused = &{1'b0, addra[31:ADDR_WIDTH+2], addra[1:0]};

  always_ff @(posedge clk) begin
    if (ena && wea) r_mem[w_idx] <= dina;
  end

  // Read-first: the old word is captured even when the same edge writes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_douta <= '0;
    else if (ena) r_douta <= r_mem[w_idx];
  end

  assign douta = r_douta;

  // ---------------- fp32 adder ----------------
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_swap, w_sub, w_up;
  logic [31:0]       w_big, w_sml;
  logic [7:0]        w_dexp;
  logic [4:0]        w_shamt, w_lz;
  logic [49:0]       w_sml_sh;
  logic [26:0]       w_big_x, w_sml_x, w_norm;
  logic [27:0]       w_sum;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac;
  logic signed [9:0] w_big_e, w_exp_n, w_exp_r;

  assign w_a_zero = (add_a[30:23] == 8'h00);
  assign w_b_zero = (add_b[30:23] == 8'h00);
  assign w_a_inf  = (add_a[30:23] == 8'hFF) && (add_a[22:0] == 23'd0);
  assign w_b_inf  = (add_b[30:23] == 8'hFF) && (add_b[22:0] == 23'd0);
  assign w_a_nan  = (add_a[30:23] == 8'hFF) && (add_a[22:0] != 23'd0);
  assign w_b_nan  = (add_b[30:23] == 8'hFF) && (add_b[22:0] != 23'd0);

  // Order operands by magnitude so the difference is never negative.
  assign w_swap  = (add_b[30:0] > add_a[30:0]);
  assign w_big   = w_swap ? add_b : add_a;
  assign w_sml   = w_swap ? add_a : add_b;
  assign w_sub   = w_big[31] ^ w_sml[31];
  assign w_dexp  = w_big[30:23] - w_sml[30:23];
  assign w_shamt = (w_dexp > 8'd31) ? 5'd31 : w_dexp[4:0];

  assign w_sml_sh = {1'b1, w_sml[22:0], 26'd0} >> w_shamt;
  assign w_sml_x  = {w_sml_sh[49:24], |w_sml_sh[23:0]};
  assign w_big_x  = {1'b1, w_big[22:0], 3'b000};
  assign w_sum    = w_sub ? ({1'b0, w_big_x} - {1'b0, w_sml_x})
                          : ({1'b0, w_big_x} + {1'b0, w_sml_x});
  assign w_big_e  = $signed({2'b00, w_big[30:23]});

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end
  end

  always_comb begin
    w_norm  = w_sum[26:0] << w_lz;
    w_exp_n = w_big_e - $signed({5'b00000, w_lz});
    if (w_sum[27]) begin
      w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp_n = w_big_e + 10'sd1;
    end
  end

  // Round to nearest even on guard/round/sticky.
  assign w_up    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mant  = {1'b0, w_norm[26:3]} + {24'd0, w_up};
  assign w_exp_r = w_exp_n + $signed({9'd0, w_mant[24]});
  assign w_frac  = w_mant[24] ? w_mant[23:1] : w_mant[22:0];

  always_comb begin
    add_result = {w_big[31], w_exp_r[7:0], w_frac};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (add_a[31] != add_b[31]))) begin
      add_result = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      add_result = add_a;
    end else if (w_b_inf) begin
      add_result = add_b;
    end else if (w_a_zero && w_b_zero) begin
      add_result = {add_a[31] & add_b[31], 31'd0};
    end else if (w_a_zero) begin
      add_result = add_b;
    end else if (w_b_zero) begin
      add_result = add_a;
    end else if ((w_sum == 28'd0) || (w_exp_n <= 10'sd0)) begin
      add_result = 32'h0000_0000;
    end else if (w_exp_r >= 10'sd255) begin
      add_result = {w_big[31], 8'hFF, 23'd0};
    end
  end

endmodule

// File: tb/tb_pulse_bram_fp32_acc.sv
// Self-checking bench: directed scenarios plus randomized BRAM traffic and fp32 sums,
// compared against an exact-arithmetic adder model and an array memory model.
module tb_pulse_bram_fp32_acc;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        wea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_result;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_dout;

  pulse_bram_fp32_acc #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta), .add_a(add_a), .add_b(add_b), .add_result(add_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact sum on a wide integer grid, then a single rounding to fp32.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, rs, an, bn, ai, bi, az, bz;
    int           ea, eb, emin, p, be, sh;
    logic [299:0] ma_w, mb_w, mag, rem, half, one;
    logic [24:0]  q;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0); bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0); bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0); bz = (eb == 0);
    if (an || bn || (ai && bi && (sa != sb))) return 32'h7FC0_0000;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {sa & sb, 31'd0};
    if (az) return b;
    if (bz) return a;
    emin = (ea < eb) ? ea : eb;
    ma_w = 300'({1'b1, a[22:0]}) << (ea - emin);
    mb_w = 300'({1'b1, b[22:0]}) << (eb - emin);
    if (sa == sb) begin
      mag = ma_w + mb_w; rs = sa;
    end else if (ma_w >= mb_w) begin
      mag = ma_w - mb_w; rs = sa;
    end else begin
      mag = mb_w - ma_w; rs = sb;
    end
    if (mag == 0) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    be = emin - 23 + p;
    one = 300'd1;
    if (p > 23) begin
      sh   = p - 23;
      q    = 25'(mag >> sh);
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 25'd1;
    end else begin
      q = 25'(mag << (23 - p));
    end
    if (q[24]) begin
      q  = q >> 1;
      be = be + 1;
    end
    if (be >= 255) return {rs, 8'hFF, 23'd0};
    if (be <= 0) return 32'h0000_0000;
    return {rs, 8'(be), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          k = int'($urandom_range(0, 19));
    logic [31:0] v = $urandom();
    case (k)
      0: v[30:0] = 31'd0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: begin v[30:23] = 8'hFF; if (v[22:0] == 23'd0) v[0] = 1'b1; end
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'hFE;
      default: begin
        if (v[30:23] == 8'hFF) v[30:23] = 8'h80;
        if (v[30:23] == 8'h00) v[30:23] = 8'h01;
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rnd_partner(input logic [31:0] a);
    int          mode = int'($urandom_range(0, 3));
    int          e;
    logic [31:0] v = $urandom();
    case (mode)
      0: v = rnd_fp();
      1: v = a ^ 32'h8000_0000;
      2: begin
        e = int'(a[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
      default: v = {~a[31], a[30:0] ^ 31'($urandom_range(0, 7))};
    endcase
    return v;
  endfunction

  // One clock of BRAM traffic; the model applies read-first semantics at the edge.
  task automatic bram_cycle(input logic en, input logic we, input logic [31:0] addr,
                            input logic [31:0] din);
    logic [ADDR_WIDTH-1:0] idx;
    ena = en; wea = we; addra = addr; dina = din;
    @(posedge clk);
    #1;
    idx = addr[ADDR_WIDTH+1:2];
    if (en) begin
      ref_dout = ref_mem[idx];
      if (we) ref_mem[idx] = din;
    end
    check($sformatf("douta@%h", addr), douta, ref_dout);
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    add_a = a; add_b = b;
    #1;
    check($sformatf("add %h+%h", a, b), add_result, exp);
  endtask

  task automatic rmw(input logic [31:0] addr, input logic [31:0] coef);
    logic [31:0] s;
    bram_cycle(1'b1, 1'b0, addr, 32'd0);
    add_a = douta; add_b = coef;
    #1;
    s = add_result;
    check("rmw_sum", s, ref_add(ref_dout, coef));
    bram_cycle(1'b1, 1'b1, addr, s);
  endtask

  initial begin
    logic [31:0] a, b, addr;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'd0;
    ref_dout = 32'd0;
    rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = 32'd0; dina = 32'd0;
    add_a = 32'd0; add_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_douta", douta, 32'd0);
    rst = 1'b0;

    // Write then read back, and an untouched neighbour.
    bram_cycle(1'b1, 1'b1, 32'h10, 32'h3F80_0000);
    bram_cycle(1'b1, 1'b0, 32'h10, 32'd0);
    check("rd_0x10", douta, 32'h3F80_0000);
    bram_cycle(1'b1, 1'b0, 32'h14, 32'd0);
    check("rd_0x14", douta, 32'h0000_0000);

    // Mid-run asynchronous reset clears douta only.
    bram_cycle(1'b1, 1'b0, 32'h10, 32'd0);
    #2 rst = 1'b1;
    #1 ref_dout = 32'd0;
    check("rst_async", douta, 32'd0);
    #1 rst = 1'b0;
    bram_cycle(1'b1, 1'b0, 32'h10, 32'd0);
    check("rst_keep_mem", douta, 32'h3F80_0000);
    bram_cycle(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    bram_cycle(1'b1, 1'b0, 32'h10, 32'd0);
    check("ena0_no_write", douta, 32'h3F80_0000);

    add_vec(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    add_vec(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    add_vec(32'h0000_0000, 32'h3D7C_5048, 32'h3D7C_5048);
    add_vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    add_vec(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    add_vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    add_vec(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    add_vec(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    add_vec(32'h0080_0001, 32'h8080_0000, 32'h0000_0000);

    // Two accumulation passes at 0x40.
    rmw(32'h40, 32'h3E99_652C);
    bram_cycle(1'b1, 1'b0, 32'h40, 32'd0);
    check("rmw_pass1", douta, 32'h3E99_652C);
    rmw(32'h40, 32'h3E99_652C);
    bram_cycle(1'b1, 1'b0, 32'h40, 32'd0);
    check("rmw_pass2", douta, 32'h3F19_652C);

    // Address wrap past the top of the array.
    bram_cycle(1'b1, 1'b1, 32'h4000, 32'hDEAD_BEEF);
    bram_cycle(1'b1, 1'b0, 32'h0, 32'd0);
    check("wrap_0x4000", douta, 32'hDEAD_BEEF);

    // Same-cycle read and write returns the old word.
    bram_cycle(1'b1, 1'b1, 32'h20, 32'h3F80_0000);
    bram_cycle(1'b1, 1'b1, 32'h20, 32'h4000_0000);
    check("rw_old", douta, 32'h3F80_0000);
    bram_cycle(1'b1, 1'b0, 32'h20, 32'd0);
    check("rw_new", douta, 32'h4000_0000);

    for (int n = 0; n < 600; n++) begin
      a = rnd_fp();
      b = rnd_partner(a);
      if ($urandom_range(0, 1) == 1) add_vec(b, a, ref_add(b, a));
      else                            add_vec(a, b, ref_add(a, b));
    end

    for (int n = 0; n < 400; n++) begin
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[13:2] = 12'($urandom_range(0, 7));
      else                            addr[13:2] = 12'($urandom_range(4088, 4095));
      bram_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), addr, $urandom());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
